// File: rtl/izigzag_pkg.sv
// Shared constants and zigzag map for the JPEG zigzag pages.
// Latency: none; constants and a table only.
// Backpressure: not applicable.
package izigzag_pkg;

    localparam int W_DEF = 16;
    localparam int BLK   = 64;

    // Zigzag scan index -> natural raster position within an 8x8 block.
    localparam logic [5:0] ZZ [BLK] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/izigzag_rom.sv
// Zigzag index to natural position lookup.
// Latency: combinational.
// Backpressure: none; pure lookup.
module izigzag_rom
    import izigzag_pkg::*;
(
    input  logic [5:0] zzIdx,
    output logic [5:0] natPos
);

    assign natPos = ZZ[zzIdx];

endmodule

// File: rtl/izigzag_reorder.sv
// Inverse zigzag reorder: zigzag-order blocks in, natural-order blocks out, ping-pong banked.
// Latency: first output one cycle after a block's last accept when the read bank is free.
// Backpressure: in_b from registers only (write bank full or EOS pending); output holds under out_b.
module izigzag_reorder
    import izigzag_pkg::*;
#(
    parameter int W = W_DEF
)
(
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in_d,
    input  logic         in_e,
    input  logic         in_v,
    output logic         in_b,
    output logic [W-1:0] out_d,
    output logic         out_e,
    output logic         out_v,
    input  logic         out_b
);

    logic [W-1:0]   bankMem   [2][BLK];
    logic [BLK-1:0] validMask [2];
    logic [1:0]     fullFlag;
    logic           wrBank;
    logic           rdBank;
    logic [5:0]     fillCnt;
    logic [5:0]     drainCnt;
    logic           eosPending;
    logic [5:0]     natIdx;

    logic inAcc;
    logic dataAcc;
    logic outLoad;
    logic canDrain;
    logic canEos;
    logic lastFill;
    logic lastDrain;
    logic closeBlk;

    izigzag_rom uRom (
        .zzIdx  (fillCnt),
        .natPos (natIdx)
    );

    // Upstream is held off while the write bank is occupied or an EOS is still queued.
    assign in_b      = fullFlag[wrBank] | eosPending;
    assign inAcc     = in_v & ~in_b;
    assign dataAcc   = inAcc & ~in_e;
    assign outLoad   = ~out_v | ~out_b;
    assign canDrain  = outLoad & fullFlag[rdBank];
    // EOS trails every closed block, so it waits until both banks are empty.
    assign canEos    = outLoad & eosPending & ~|fullFlag;
    assign lastFill  = (fillCnt == 6'(BLK - 1));
    assign lastDrain = (drainCnt == 6'(BLK - 1));
    // A block closes on its 64th coefficient, or early on EOS if it holds anything.
    assign closeBlk  = (dataAcc & lastFill) | (inAcc & in_e & (fillCnt != 6'd0));

    // Coefficient storage; unwritten entries are masked so the data needs no reset.
    always_ff @(posedge clock) begin
        if (dataAcc) begin
            bankMem[wrBank][natIdx] <= in_d;
        end
    end

    // Fill/drain bookkeeping; fill and drain always touch different banks on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fullFlag   <= 2'b00;
            validMask  <= '{default: '0};
            wrBank     <= 1'b0;
            rdBank     <= 1'b0;
            fillCnt    <= 6'd0;
            drainCnt   <= 6'd0;
            eosPending <= 1'b0;
        end else begin
            if (canDrain) begin
                drainCnt <= drainCnt + 6'd1;
                if (lastDrain) begin
                    fullFlag[rdBank]  <= 1'b0;
                    validMask[rdBank] <= '0;
                    rdBank            <= ~rdBank;
                end
            end
            if (dataAcc) begin
                validMask[wrBank][natIdx] <= 1'b1;
            end
            if (closeBlk) begin
                fullFlag[wrBank] <= 1'b1;
                wrBank           <= ~wrBank;
                fillCnt          <= 6'd0;
            end else if (dataAcc) begin
                fillCnt <= fillCnt + 6'd1;
            end
            if (inAcc && in_e) begin
                eosPending <= 1'b1;
            end else if (canEos) begin
                eosPending <= 1'b0;
            end
        end
    end

    // Output register: next natural-order coefficient, else the pending EOS, else go idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_d <= '0;
            out_e <= 1'b0;
            out_v <= 1'b0;
        end else if (outLoad) begin
            if (fullFlag[rdBank]) begin
                out_d <= validMask[rdBank][drainCnt] ? bankMem[rdBank][drainCnt] : '0;
                out_e <= 1'b0;
                out_v <= 1'b1;
            end else if (canEos) begin
                out_d <= '0;
                out_e <= 1'b1;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_izigzag_reorder.sv
// Self-checking bench for izigzag_reorder: scoreboard of expected natural-order tokens.
// Latency: n/a.
// Backpressure: driven by the bench through out_b.
module tb_izigzag_reorder;

    localparam int W = 16;

    typedef struct packed {
        logic         e;
        logic [W-1:0] d;
    } tok_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] in_d;
    logic         in_e;
    logic         in_v;
    logic         in_b;
    logic [W-1:0] out_d;
    logic         out_e;
    logic         out_v;
    logic         out_b;

    izigzag_reorder #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .in_d  (in_d),
        .in_e  (in_e),
        .in_v  (in_v),
        .in_b  (in_b),
        .out_d (out_d),
        .out_e (out_e),
        .out_v (out_v),
        .out_b (out_b)
    );

    always #5 clock = ~clock;

    tok_t         expQ [$];
    int           checks      = 0;
    int           failures    = 0;
    int           cycle       = 0;
    int           outCount    = 0;
    int           firstOutCyc = 0;
    int           lastOutCyc  = 0;
    bit           streamPhase = 1'b0;
    int           zzTb [64];
    logic [W-1:0] mdl [64];
    logic [63:0]  mdlMask = '0;
    int           mdlK = 0;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Zigzag order derived independently by walking the anti-diagonals of the 8x8 block.
    task automatic buildZigzag();
        int idx;
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zzTb[idx] = r * 8 + (s - r);
                    idx++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zzTb[idx] = r * 8 + (s - r);
                    idx++;
                end
            end
        end
    endtask

    task automatic closeBlock();
        tok_t t;
        for (int i = 0; i < 64; i++) begin
            t.e = 1'b0;
            t.d = mdlMask[i] ? mdl[i] : '0;
            expQ.push_back(t);
        end
        mdlMask = '0;
        mdlK    = 0;
    endtask

    task automatic modelAccept(input logic [W-1:0] d, input logic e);
        tok_t t;
        if (!e) begin
            mdl[zzTb[mdlK]]     = d;
            mdlMask[zzTb[mdlK]] = 1'b1;
            mdlK++;
            if (mdlK == 64) closeBlock();
        end else begin
            if (mdlK > 0) closeBlock();
            t.e = 1'b1;
            t.d = '0;
            expQ.push_back(t);
        end
    endtask

    // Offer one token; entered and left just after a rising edge.
    task automatic pushTok(input logic [W-1:0] d, input logic e, input int bound, output bit ok);
        in_d = d;
        in_e = e;
        in_v = 1'b1;
        ok   = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (!in_b) begin
                ok = 1'b1;
                modelAccept(d, e);
                @(posedge clock);
                #1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) in_v = 1'b0;
    endtask

    task automatic sendOk(input logic [W-1:0] d, input logic e);
        bit ok;
        pushTok(d, e, 200, ok);
        if (!ok) checkVal("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 600 && expQ.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        repeat (3) @(posedge clock);
        #1;
        checkVal("drain_left", 32'(expQ.size()), 32'd0);
    endtask

    always @(posedge clock) cycle++;

    // Monitor: a token transfers at the next rising edge when out_v && !out_b.
    always @(negedge clock) begin : mon
        tok_t t;
        if (!reset && out_v && !out_b) begin
            if (expQ.size() == 0) begin
                checkVal("spurious_out", 32'(out_v), 32'd0);
            end else begin
                t = expQ.pop_front();
                checkVal("out_e", 32'(out_e), 32'(t.e));
                checkVal("out_d", 32'(out_d), 32'(t.d));
            end
            if (outCount == 0) firstOutCyc = cycle;
            lastOutCyc = cycle;
            outCount++;
        end
        if (streamPhase) checkVal("stream_in_b", 32'(in_b), 32'd0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int accepted;
        bit ok;
        buildZigzag();
        reset = 1'b1;
        in_d  = '0;
        in_e  = 1'b0;
        in_v  = 1'b0;
        out_b = 1'b0;
        #1;
        checkVal("rst_out_v", 32'(out_v), 32'd0);
        checkVal("rst_out_e", 32'(out_e), 32'd0);
        checkVal("rst_out_d", 32'(out_d), 32'd0);
        checkVal("rst_in_b", 32'(in_b), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single block carrying its own natural positions: output must count 0..63.
        for (int k = 0; k < 64; k++) sendOk(W'(zzTb[k]), 1'b0);
        in_v = 1'b0;
        checkVal("lat_pre_v", 32'(out_v), 32'd0);
        @(posedge clock);
        #1;
        checkVal("lat_v", 32'(out_v), 32'd1);
        checkVal("lat_d0", 32'(out_d), 32'd0);
        waitDrain();

        // Three blocks back-to-back with no output backpressure.
        outCount    = 0;
        streamPhase = 1'b1;
        for (int k = 0; k < 192; k++) sendOk(W'($urandom), 1'b0);
        in_v = 1'b0;
        waitDrain();
        streamPhase = 1'b0;
        checkVal("stream_count", 32'(outCount), 32'd192);
        checkVal("stream_span", 32'(lastOutCyc - firstOutCyc), 32'd191);

        // Output stalled: two blocks fit, the third is refused.
        out_b    = 1'b1;
        accepted = 0;
        for (int k = 0; k < 130; k++) begin
            pushTok(W'($urandom), 1'b0, 20, ok);
            if (!ok) break;
            accepted++;
        end
        in_v = 1'b0;
        checkVal("stall_accepted", 32'(accepted), 32'd128);
        checkVal("stall_in_b", 32'(in_b), 32'd1);
        checkVal("stall_out_v", 32'(out_v), 32'd1);
        checkVal("stall_d", 32'(out_d), 32'(expQ[0].d));
        repeat (5) @(posedge clock);
        #1;
        checkVal("stall_hold_d", 32'(out_d), 32'(expQ[0].d));
        outCount = 0;
        out_b    = 1'b0;
        for (int i = 0; i < 100 && in_b; i++) begin
            @(posedge clock);
            #1;
        end
        checkVal("stall_release_in_b", 32'(in_b), 32'd0);
        checkVal("stall_out_before_in_b", 32'(outCount), 32'd63);
        waitDrain();

        // Partial block of ten then EOS: masked zeros fill the rest, EOS follows.
        for (int k = 0; k < 10; k++) sendOk(W'(100 + k), 1'b0);
        sendOk('0, 1'b1);
        in_v = 1'b0;
        checkVal("peos_in_b", 32'(in_b), 32'd1);
        waitDrain();

        // EOS on an empty core.
        sendOk('0, 1'b1);
        in_v = 1'b0;
        checkVal("eos_in_b", 32'(in_b), 32'd1);
        checkVal("eos_pre_v", 32'(out_v), 32'd0);
        @(posedge clock);
        #1;
        checkVal("eos_v", 32'(out_v), 32'd1);
        checkVal("eos_e", 32'(out_e), 32'd1);
        checkVal("eos_d", 32'(out_d), 32'd0);
        checkVal("eos_in_b_drop", 32'(in_b), 32'd0);
        waitDrain();

        // Reset in the middle of draining a block.
        outCount = 0;
        for (int k = 0; k < 64; k++) sendOk(W'($urandom), 1'b0);
        in_v = 1'b0;
        for (int i = 0; i < 200 && outCount < 20; i++) begin
            @(posedge clock);
            #1;
        end
        checkVal("rst_mid_reached", 32'(outCount), 32'd20);
        #1;
        reset = 1'b1;
        #1;
        checkVal("rst_mid_out_v", 32'(out_v), 32'd0);
        expQ.delete();
        mdlMask = '0;
        mdlK    = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkVal("rst_mid_in_b", 32'(in_b), 32'd0);
        outCount = 0;
        repeat (80) @(posedge clock);
        #1;
        checkVal("rst_mid_silent", 32'(outCount), 32'd0);
        for (int k = 0; k < 64; k++) sendOk(W'($urandom), 1'b0);
        in_v = 1'b0;
        waitDrain();
        checkVal("rst_recover_count", 32'(outCount), 32'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/izigzag_reorder.md
Name: izigzag_reorder

Overview:
- Inverse-zigzag reorder core for the JPEG decode pipeline.
- Sits directly downstream of the izigzag page input queue and consumes its 16-bit data + EOS stream.
- Accepts 64 coefficients per block in zigzag order and emits them in natural raster order (0..63).
- Ping-pong banks let one block fill while the previous block drains, sustaining 1 token/cycle.

Parameters:
- W, 16, coefficient data width.
- BLK, 64, coefficients per block. Fixed; the zigzag table is defined only for 64.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_d  input  W  coefficient in zigzag order.
- in_e  input  1  EOS marker; in_d ignored when set.
- in_v  input  1  input token valid.
- in_b  output  1  back-pressure to upstream queue.
- out_d  output  W  coefficient in natural order.
- out_e  output  1  EOS marker out.
- out_v  output  1  output token valid.
- out_b  input  1  back-pressure from downstream.

Behaviour:
- Handshakes:
  - Input transfer when in_v && !in_b; output transfer when out_v && !out_b.
  - in_b is a function of registers only; no combinational path from out_b.
- Reset (asynchronous assert):
  - out_d=0, out_e=0, out_v=0, in_b=0.
  - Both banks EMPTY; counters k=n=0; write bank=read bank=0; eos_pending=0; valid masks cleared.
  - Reset mid-operation discards all buffered data; no stale token appears after release.
- Storage:
  - Two banks of 64xW registers, each with a 64-bit written-mask and a FULL flag.
- Fill (write bank wb, counter k = 0..63):
  - Accepted data token writes bank[wb][ZZ[k]] = in_d and sets mask bit ZZ[k].
  - When k==63 is accepted: set FULL[wb], toggle wb, k=0.
- in_b = 1 when FULL[wb] (both banks occupied), or when eos_pending=1; otherwise 0.
- Drain (read bank rb, counter n = 0..63):
  - Output register loads when !out_v || !out_b.
  - If FULL[rb]: out_d = mask[n] ? bank[rb][n] : 0, out_e=0, out_v=1, n++.
  - After n==63 loads: clear FULL[rb] and mask[rb], toggle rb, n=0.
  - If nothing is loadable, out_v drops to 0 on the next edge (once the held token is accepted).
- Latency: a block's first output is valid one cycle after its 64th input is accepted, provided rb is free. Back-to-back blocks stream with no bubbles.
- EOS accepted (in_e=1):
  - If k>0: the partial block is closed (FULL[wb]=1, wb toggles, k=0). Unwritten positions emit 0 via the mask.
  - eos_pending=1 in all cases.
- EOS emission:
  - Condition: eos_pending && both FULL flags clear && output register loadable.
  - Action: load out_e=1, out_d=0, out_v=1; clear eos_pending.
  - in_b drops the cycle after.
- Simultaneous events:
  - A bank finishing drain and the other finishing fill on the same edge are both honoured.
  - in_b reflects the post-edge state.
- Hold: out_d/out_e/out_v are stable while out_v && out_b.

Decomposition:
- Shared package izigzag_pkg:
  - constants W_DEF=16, BLK=64.
  - ZZ table: 64 x 6-bit zigzag-index to natural-position map, starting 0,1,8,16,9,2,3,10,17,24,32,25,…,62,63.
- Sub-module izigzag_rom: combinational ZZ lookup, 6-bit in to 6-bit out. Also used by the forward zigzag page.
- Bank storage, fill FSM and drain FSM stay in izigzag_reorder.

Test Plan:
- Single block ordering: feed in_d=ZZ[k] for k=0..63, out_b=0 -> out_d = 0,1,2,…,63 on consecutive cycles. First out_v is one cycle after the 64th accept.
- Streaming: 3 blocks back-to-back, in_v=1, out_b=0 -> 192 outputs with no gaps; in_b never 1.
- Stall: out_b=1 throughout, feed 130 tokens -> exactly 128 accepted, then in_b=1. out_v=1 with out_d held at block0 position 0. Release out_b -> drain resumes in order and in_b drops once block0 finishes.
- Partial + EOS: 10 tokens in_d=100+k, then EOS -> 64 outputs. Positions ZZ[0..9] (0,1,8,16,9,2,3,10,17,24) carry 100..109; all others are 0. Then one token with out_e=1, out_d=0.
- EOS on empty: EOS with no data -> one token out_e=1, out_d=0 on the next cycle; in_b=1 only for that one cycle.
- Reset mid-drain: assert reset at output n=20 -> out_v=0 immediately (asynchronous). After release, in_b=0 and no output appears until a new full block arrives.
